// File: rtl/instruction_buffer_if.sv
// Fetch/dispatch bundle for the instruction buffer. The master side is the
// fetch and dispatch environment, and the slave side is the buffer itself.
interface instruction_buffer_if #(
   parameter int N      = 3,
   parameter int IB_SZ  = 16,
   parameter int INST_W = 32,
   parameter int PC_W   = 32,
   parameter int CNT_W  = $clog2(N + 1),
   parameter int OCC_W  = $clog2(IB_SZ + 1)
);
   logic [N*INST_W-1:0] fetch_insts;
   logic [N*PC_W-1:0]   fetch_pcs;
   logic [N-1:0]        fetch_pred_taken;
   logic [CNT_W-1:0]    fetch_valid;
   logic [CNT_W-1:0]    ib_spots;
   logic [N*INST_W-1:0] instruction_insts;
   logic [N*PC_W-1:0]   instruction_pcs;
   logic [N-1:0]        instruction_pred_taken;
   logic [CNT_W-1:0]    instructions_valid;
   logic [CNT_W-1:0]    num_dispatched;
   logic                flush;
   logic [OCC_W-1:0]    occupancy;

   modport master (
      output fetch_insts, fetch_pcs, fetch_pred_taken, fetch_valid,
             num_dispatched, flush,
      input  ib_spots, instruction_insts, instruction_pcs,
             instruction_pred_taken, instructions_valid, occupancy
   );

   modport slave (
      input  fetch_insts, fetch_pcs, fetch_pred_taken, fetch_valid,
             num_dispatched, flush,
      output ib_spots, instruction_insts, instruction_pcs,
             instruction_pred_taken, instructions_valid, occupancy
   );
endinterface

// File: rtl/instruction_buffer.sv
// Circular instruction FIFO between fetch and dispatch. It accepts up to N
// pushes and N pops per cycle, and a flush empties it.
module instruction_buffer #(
   parameter int N      = 3,
   parameter int IB_SZ  = 16,
   parameter int INST_W = 32,
   parameter int PC_W   = 32
) (
   input logic                clock,
   input logic                reset,
   instruction_buffer_if.slave ib
);
   localparam int CNT_W = $clog2(N + 1);
   localparam int OCC_W = $clog2(IB_SZ + 1);
   localparam int PTR_W = $clog2(IB_SZ);

   logic [INST_W-1:0] mem_inst_q [IB_SZ];
   logic [PC_W-1:0]   mem_pc_q   [IB_SZ];
   logic              mem_pt_q   [IB_SZ];

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic [OCC_W-1:0] free;
   logic [CNT_W-1:0] spots, valid, push, pop;

   logic [N*INST_W-1:0] out_insts;
   logic [N*PC_W-1:0]   out_pcs;
   logic [N-1:0]        out_pt;

   // spots and valid depend only on registered state, so a same-cycle pop
   // never opens extra room for fetch.
   always_comb begin
      free  = OCC_W'(IB_SZ) - occ_q;
      spots = (free < OCC_W'(N)) ? CNT_W'(free) : CNT_W'(N);
      valid = (occ_q < OCC_W'(N)) ? CNT_W'(occ_q) : CNT_W'(N);
      push  = (ib.fetch_valid < spots) ? ib.fetch_valid : spots;
      pop   = (ib.num_dispatched < valid) ? ib.num_dispatched : valid;
   end

   always_comb begin
      head_d = head_q + PTR_W'(pop);
      tail_d = tail_q + PTR_W'(push);
      occ_d  = occ_q + OCC_W'(push) - OCC_W'(pop);
      if (ib.flush) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   // Storage has no reset; entries outside the occupied window are never observed.
   always_ff @(posedge clock) begin
      for (int j = 0; j < N; j++) begin
         if (!ib.flush && (CNT_W'(j) < push)) begin
            mem_inst_q[tail_q + PTR_W'(j)] <= ib.fetch_insts[j*INST_W +: INST_W];
            mem_pc_q[tail_q + PTR_W'(j)]   <= ib.fetch_pcs[j*PC_W +: PC_W];
            mem_pt_q[tail_q + PTR_W'(j)]   <= ib.fetch_pred_taken[j];
         end
      end
   end

   always_comb begin
      out_insts = '0;
      out_pcs   = '0;
      out_pt    = '0;
      for (int i = 0; i < N; i++) begin
         if (CNT_W'(i) < valid) begin
            out_insts[i*INST_W +: INST_W] = mem_inst_q[head_q + PTR_W'(i)];
            out_pcs[i*PC_W +: PC_W]       = mem_pc_q[head_q + PTR_W'(i)];
            out_pt[i]                     = mem_pt_q[head_q + PTR_W'(i)];
         end
      end
   end

   assign ib.ib_spots               = spots;
   assign ib.instructions_valid     = valid;
   assign ib.instruction_insts      = out_insts;
   assign ib.instruction_pcs        = out_pcs;
   assign ib.instruction_pred_taken = out_pt;
   assign ib.occupancy              = occ_q;
endmodule

// File: doc/instruction_buffer.md
Name: instruction_buffer

Overview:
Circular FIFO between fetch and dispatch. Accepts up to N fetched instructions per cycle. Presents the oldest up to N entries to dispatch as instruction packets plus a valid count. Retires exactly the num_dispatched entries that dispatch reports. Empties completely on a branch-mispredict flush.

Parameters:
N, 3, superscalar width (max entries pushed, presented and popped per cycle)
IB_SZ, 16, buffer depth in entries; power of two, IB_SZ >= N
INST_W, 32, instruction word width
PC_W, 32, PC width
CNT_W, $clog2(N+1), width of per-cycle count signals (NUM_SCALAR_BITS)
OCC_W, $clog2(IB_SZ+1), width of occupancy count

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous active-high reset
fetch_insts  in  N*INST_W  fetched instruction words; slot 0 oldest
fetch_pcs  in  N*PC_W  PC per fetch slot
fetch_pred_taken  in  N  branch-predictor taken bit per slot
fetch_valid  in  CNT_W  number of valid fetch slots; slots 0..fetch_valid-1 are valid
ib_spots  out  CNT_W  entries fetch may push this cycle
instruction_insts  out  N*INST_W  oldest entries; slot 0 = head
instruction_pcs  out  N*PC_W  PCs of presented entries
instruction_pred_taken  out  N  predictor bits of presented entries
instructions_valid  out  CNT_W  number of valid presented slots
num_dispatched  in  CNT_W  entries dispatch consumed this cycle
flush  in  1  mispredict restore; discard all contents
occupancy  out  OCC_W  current entry count (debug and verification)

Behaviour:
- State: storage array of IB_SZ entries {inst, pc, pred_taken}, head ptr, tail ptr, occupancy counter.
- Pointers are log2(IB_SZ) bits and wrap naturally modulo IB_SZ.
- Reset (async, any time, including mid-operation): head=0, tail=0, occupancy=0. All outputs read as 0 immediately, except ib_spots=min(IB_SZ,N). Storage contents are don't-care.
- ib_spots = min(IB_SZ - occupancy, N). Combinational from registered state only.
- Space freed by a same-cycle pop does not raise ib_spots.
- instructions_valid = min(occupancy, N).
- Output slot i = storage[(head+i) mod IB_SZ] for i < instructions_valid.
- Output slots at i >= instructions_valid are driven all-zero.
- Outputs are combinational from registered state. There is no fetch-to-dispatch bypass: an entry pushed at edge k is first presented after edge k.
- Push amount each edge: push = min(fetch_valid, ib_spots). Excess fetch slots are dropped. Fetch must honour ib_spots; the bench treats an excess as a protocol violation.
- Pushed slot j is written to (tail+j) mod IB_SZ, then tail += push.
- Pop amount each edge: pop = min(num_dispatched, instructions_valid). An over-request is clamped, never underflows. Then head += pop.
- occupancy_next = occupancy + push - pop. Simultaneous push and pop are fully supported, including at full and at empty.
- flush=1 at an edge has priority over push and pop. Next state is head=0, tail=0, occupancy=0, and that cycle's fetch data is discarded.
- One cycle after flush, instructions_valid=0 and ib_spots=min(IB_SZ,N).
- Wrap-around: any push or present window may straddle index IB_SZ-1 to 0. Ordering is preserved.
- Invariants:
  - occupancy <= IB_SZ.
  - (tail - head) mod IB_SZ == occupancy mod IB_SZ.
  - occupancy==IB_SZ implies ib_spots=0.
  - occupancy==0 implies instructions_valid=0.
- No combinational path from num_dispatched or flush to any output.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with 5 entries held -> immediately occupancy=0, instructions_valid=0, ib_spots=3, all instruction outputs 0; after release the buffer stays empty.
- Basic flow: push 3 entries (pcs 0x0,0x4,0x8), num_dispatched=0 -> next cycle instructions_valid=3, instruction_pcs slots = 0x0,0x4,0x8. Then num_dispatched=2 -> next cycle instructions_valid=1, slot0 pc=0x8.
- Full: push 3 per cycle with no pops for 6 cycles -> occupancy 16, ib_spots=0 from the 6th cycle. A push of 3 at full is dropped and occupancy stays 16. Same-cycle pop 3 plus push 3 at occupancy 16 -> occupancy 13 and only 0 pushed.
- Wrap-around: cycle head to 14 via push/pop, then push 3 -> entries land at indices 14,15,0. Presented order equals push order, and PCs match the golden queue.
- Flush priority: occupancy 7, same cycle flush=1, fetch_valid=3, num_dispatched=2 -> next cycle occupancy=0, instructions_valid=0. The following push of 1 (pc 0x100) is presented alone.
- Over-pop and random: occupancy 1, num_dispatched=3 -> occupancy 0, no underflow. Then 1000 random cycles (flush 10%) checked against a golden queue model on every presented slot and count.
